pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It watches ID-stage operand usage, EX-stage load/MDU issue, ID branch resolution and the MEM-stage data-memory handshake. It drives the stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also tracks multiply/divide busy time and counts stall cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl_mdu_busy_cnt.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared pipeline definitions for the hazard controller: controller state
// encoding, register-number width, the hard-wired zero register and a small
// operand-match helper used by the load-use detector.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] R0 = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // True when the ID instruction actually reads 'src' and it equals 'dst'.
    function automatic logic srcMatch(input logic uses,
                                      input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the pipeline-side signals of the hazard controller.
//   master : pipeline side, drives stage status, receives stall/flush controls
//   slave  : hazard controller, the reverse
// Inputs to the controller : RsD, RtD, UsesRsD, UsesRtD, WriteRegE, MemReadE,
//                            MduStartE, MduUseD, BranchTakenD, DMemReqM,
//                            DMemReadyM
// Outputs of the controller: PC_Stall, IF_Stall, IF_Flush, ID_EX_Stall,
//                            ID_EX_Flush, EX_MEM_Stall, MEM_WB_Flush,
//                            MduBusy, MemErr, StallCount[CNT_W]
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic             UsesRsD;
    logic             UsesRtD;
    logic [REG_W-1:0] WriteRegE;
    logic             MemReadE;
    logic             MduStartE;
    logic             MduUseD;
    logic             BranchTakenD;
    logic             DMemReqM;
    logic             DMemReadyM;

    logic             PC_Stall;
    logic             IF_Stall;
    logic             IF_Flush;
    logic             ID_EX_Stall;
    logic             ID_EX_Flush;
    logic             EX_MEM_Stall;
    logic             MEM_WB_Flush;
    logic             MduBusy;
    logic             MemErr;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RsD, RtD, UsesRsD, UsesRtD, WriteRegE, MemReadE, MduStartE,
               MduUseD, BranchTakenD, DMemReqM, DMemReadyM,
        input  PC_Stall, IF_Stall, IF_Flush, ID_EX_Stall, ID_EX_Flush,
               EX_MEM_Stall, MEM_WB_Flush, MduBusy, MemErr, StallCount
    );

    modport slave (
        input  RsD, RtD, UsesRsD, UsesRtD, WriteRegE, MemReadE, MduStartE,
               MduUseD, BranchTakenD, DMemReqM, DMemReadyM,
        output PC_Stall, IF_Stall, IF_Flush, ID_EX_Stall, ID_EX_Flush,
               EX_MEM_Stall, MEM_WB_Flush, MduBusy, MemErr, StallCount
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_busy_cnt.sv
// ---------------------------------------------------------------------------
// mdu_busy_cnt
// Tracks how long the multiply/divide unit stays occupied. A load restarts
// the count at MDU_LATENCY-1; otherwise it counts down to zero and stops.
// Ports:
//   clk     in   pipeline clock
//   rst_n   in   asynchronous active-low reset
//   i_load  in   an MDU op is issued from EX this cycle
//   o_busy  out  count is non-zero
// ---------------------------------------------------------------------------
module mdu_busy_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_busy
);

    localparam int CW = $clog2(MDU_LATENCY);
    localparam logic [CW-1:0] RELOAD = CW'(MDU_LATENCY - 1);

    logic [CW-1:0] r_count;

    // A new issue always wins, so a start while busy simply restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Resolves memory
// waits, MDU interlocks, load-use hazards and taken branches (in that
// priority) into stage stall/flush controls, tracks MDU busy time, flags
// data-memory timeouts and counts PC stall cycles.
// Ports:
//   clk    in   pipeline clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   hz     slave modport of pipe_hazard_ctrl_if (stage status in,
//          stall/flush controls, MduBusy, MemErr, StallCount out)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         r_state;
    hz_state_t         w_nextState;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_waitNext;
    logic              r_memErr;
    logic [CNT_W-1:0]  r_stallCnt;

    logic w_memWait;
    logic w_loadUse;
    logic w_mduHaz;
    logic w_mduBusy;
    logic w_mduLoad;

    logic w_pcStall;
    logic w_ifStall;
    logic w_ifFlush;
    logic w_idExStall;
    logic w_idExFlush;
    logic w_exMemStall;
    logic w_memWbFlush;

    // Hazard conditions. The memory wait does not depend on the FSM state so
    // the stall lands in the same cycle the request goes out.
    assign w_memWait = hz.DMemReqM & ~hz.DMemReadyM;
    assign w_loadUse = hz.MemReadE && (hz.WriteRegE != R0) &&
                       (srcMatch(hz.UsesRsD, hz.RsD, hz.WriteRegE) ||
                        srcMatch(hz.UsesRtD, hz.RtD, hz.WriteRegE));
    assign w_mduHaz  = w_mduBusy & hz.MduUseD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:      if (w_memWait)     w_nextState = MEM_WAIT;
            MEM_WAIT: if (hz.DMemReadyM) w_nextState = RUN;
            default:                     w_nextState = RUN;
        endcase
    end

    // Reset forces the front-end flushes so the IF/ID and ID/EX registers
    // hold bubbles. A branch under any stall is left alone: ID is held and
    // the branch re-resolves next cycle.
    always_comb begin
        w_pcStall    = 1'b0;
        w_ifStall    = 1'b0;
        w_ifFlush    = 1'b0;
        w_idExStall  = 1'b0;
        w_idExFlush  = 1'b0;
        w_exMemStall = 1'b0;
        w_memWbFlush = 1'b0;
        if (!rst_n) begin
            w_ifFlush   = 1'b1;
            w_idExFlush = 1'b1;
        end else if (w_memWait) begin
            w_pcStall    = 1'b1;
            w_ifStall    = 1'b1;
            w_idExStall  = 1'b1;
            w_exMemStall = 1'b1;
            w_memWbFlush = 1'b1;
        end else if (w_mduHaz || w_loadUse) begin
            w_pcStall   = 1'b1;
            w_ifStall   = 1'b1;
            w_idExFlush = 1'b1;
        end else if (hz.BranchTakenD) begin
            w_ifFlush = 1'b1;
        end
    end

    // An MDU op frozen in EX by a memory wait has not really issued yet.
    assign w_mduLoad = hz.MduStartE & ~w_exMemStall;

    mdu_busy_cnt #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_mduLoad),
        .o_busy (w_mduBusy)
    );

    // The wait counter saturates at the limit; MemErr is sticky until reset.
    assign w_waitNext = (r_state == MEM_WAIT) ?
                        ((r_waitCnt == WAIT_LIMIT) ? r_waitCnt : r_waitCnt + 1'b1) :
                        '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt  <= '0;
            r_memErr   <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            r_waitCnt <= w_waitNext;
            if (w_waitNext == WAIT_LIMIT) begin
                r_memErr <= 1'b1;
            end
            if (w_pcStall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

    assign hz.PC_Stall     = w_pcStall;
    assign hz.IF_Stall     = w_ifStall;
    assign hz.IF_Flush     = w_ifFlush;
    assign hz.ID_EX_Stall  = w_idExStall;
    assign hz.ID_EX_Flush  = w_idExFlush;
    assign hz.EX_MEM_Stall = w_exMemStall;
    assign hz.MEM_WB_Flush = w_memWbFlush;
    assign hz.MduBusy      = w_mduBusy;
    assign hz.MemErr       = r_memErr;
    assign hz.StallCount   = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model of the hazard rules kept in this file.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int TMO     = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // Control vector order: {PC_Stall, IF_Stall, IF_Flush, ID_EX_Stall,
    //                        ID_EX_Flush, EX_MEM_Stall, MEM_WB_Flush}
    localparam logic [6:0] CTL_IDLE   = 7'b0000000;
    localparam logic [6:0] CTL_MEM    = 7'b1101011;
    localparam logic [6:0] CTL_BUBBLE = 7'b1100100;
    localparam logic [6:0] CTL_BRANCH = 7'b0010000;
    localparam logic [6:0] CTL_RESET  = 7'b0010100;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        logic       usesRs;
        logic       usesRt;
        logic       memRead;
        logic       mduStart;
        logic       mduUse;
        logic       branch;
        logic       req;
        logic       rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(
        .MDU_LATENCY (MDU_LAT),
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    logic [6:0] obsCtl;
    assign obsCtl = {hz.PC_Stall, hz.IF_Stall, hz.IF_Flush, hz.ID_EX_Stall,
                     hz.ID_EX_Flush, hz.EX_MEM_Stall, hz.MEM_WB_Flush};

    stim_t cur;
    int    mduRem;
    int    waitCycles;
    int    stallCnt;
    bit    inWait;
    bit    memErr;
    int    compared = 0;
    int    mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: priority memwait > MDU interlock / load-use > branch.
    function automatic logic [6:0] modelCtl(input stim_t s);
        bit memwait;
        bit mduhaz;
        bit loaduse;
        memwait = s.req && !s.rdy;
        mduhaz  = (mduRem > 0) && s.mduUse;
        loaduse = s.memRead && (s.wr != 0) &&
                  ((s.usesRs && s.rs == s.wr) || (s.usesRt && s.rt == s.wr));
        if (memwait)               return CTL_MEM;
        if (mduhaz || loaduse)     return CTL_BUBBLE;
        if (s.branch)              return CTL_BRANCH;
        return CTL_IDLE;
    endfunction

    task automatic applyStimulus(input stim_t s);
        cur             = s;
        hz.RsD          = s.rs;
        hz.RtD          = s.rt;
        hz.WriteRegE    = s.wr;
        hz.UsesRsD      = s.usesRs;
        hz.UsesRtD      = s.usesRt;
        hz.MemReadE     = s.memRead;
        hz.MduStartE    = s.mduStart;
        hz.MduUseD      = s.mduUse;
        hz.BranchTakenD = s.branch;
        hz.DMemReqM     = s.req;
        hz.DMemReadyM   = s.rdy;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "/ctl"},   32'(obsCtl),        32'(modelCtl(cur)));
        chk({tag, "/busy"},  32'(hz.MduBusy),    32'(mduRem > 0));
        chk({tag, "/err"},   32'(hz.MemErr),     32'(memErr));
        chk({tag, "/count"}, 32'(hz.StallCount), 32'(stallCnt));
    endtask

    // Advance one clock and move the model across the same edge.
    task automatic clockStep();
        logic [6:0] ctl;
        ctl = modelCtl(cur);
        @(posedge clk);
        if (cur.mduStart && !ctl[1]) mduRem = MDU_LAT - 1;
        else if (mduRem > 0)         mduRem--;
        if (inWait) begin
            waitCycles++;
            if (waitCycles >= TMO) memErr = 1'b1;
            if (cur.rdy) inWait = 1'b0;
        end else begin
            waitCycles = 0;
            if (cur.req && !cur.rdy) inWait = 1'b1;
        end
        if (ctl[6] && stallCnt < CNT_MAX) stallCnt++;
        @(negedge clk);
    endtask

    task automatic cycle(input stim_t s, input string tag);
        applyStimulus(s);
        #1;
        checkOutput(tag);
        clockStep();
    endtask

    // Called at a falling edge: reset asserts mid-phase, checked before any edge.
    task automatic doReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "/ctl"},   32'(obsCtl),        32'(CTL_RESET));
        chk({tag, "/busy"},  32'(hz.MduBusy),    32'd0);
        chk({tag, "/err"},   32'(hz.MemErr),     32'd0);
        chk({tag, "/count"}, 32'(hz.StallCount), 32'd0);
        mduRem = 0; waitCycles = 0; stallCnt = 0; inWait = 1'b0; memErr = 1'b0;
        @(negedge clk);
        applyStimulus('0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        applyStimulus('0);
        mduRem = 0; waitCycles = 0; stallCnt = 0; inWait = 1'b0; memErr = 1'b0;
        @(negedge clk);
        doReset("reset");

        s = '0;
        cycle(s, "idle");

        // Load-use on Rs: one bubble, then EX holds the bubble.
        s = '0; s.memRead = 1'b1; s.wr = 5'd5; s.rs = 5'd5; s.usesRs = 1'b1;
        applyStimulus(s); #1;
        chk("lu/direct", 32'(obsCtl), 32'(CTL_BUBBLE));
        checkOutput("lu"); clockStep();
        s = '0; s.rs = 5'd5; s.usesRs = 1'b1;
        cycle(s, "lu.after");

        // Destination R0 never creates a hazard.
        s = '0; s.memRead = 1'b1; s.wr = 5'd0; s.rs = 5'd0; s.usesRs = 1'b1;
        cycle(s, "lu.r0");
        s = '0; s.memRead = 1'b1; s.wr = 5'd9; s.rt = 5'd9; s.usesRt = 1'b1; s.rs = 5'd9;
        cycle(s, "lu.rt");

        // Branch coincident with load-use is not flushed; alone it is.
        s = '0; s.memRead = 1'b1; s.wr = 5'd7; s.rt = 5'd7; s.usesRt = 1'b1; s.branch = 1'b1;
        cycle(s, "br.lu");
        s = '0; s.branch = 1'b1;
        applyStimulus(s); #1;
        chk("br/direct", 32'(obsCtl), 32'(CTL_BRANCH));
        checkOutput("br"); clockStep();

        // MDU: start, then dependent op held until the unit frees.
        s = '0; s.mduStart = 1'b1;
        cycle(s, "mdu.start");
        s = '0; s.mduUse = 1'b1;
        for (int i = 0; i < 4; i++) cycle(s, "mdu.use");
        s = '0; s.mduStart = 1'b1;
        cycle(s, "mdu.start2");
        s = '0; s.mduUse = 1'b1;
        cycle(s, "mdu.mid");
        s = '0; s.mduStart = 1'b1; s.mduUse = 1'b1;
        cycle(s, "mdu.reload");
        s = '0; s.mduUse = 1'b1;
        for (int i = 0; i < 4; i++) cycle(s, "mdu.tail");

        // Memory wait of three cycles from a clean count.
        doReset("reset2");
        s = '0; s.req = 1'b1;
        for (int i = 0; i < 3; i++) cycle(s, "mem.wait");
        s.rdy = 1'b1;
        cycle(s, "mem.ready");
        chk("mem/count", 32'(hz.StallCount), 32'd3);
        s = '0;
        cycle(s, "mem.idle");

        // Timeout: ready withheld six cycles.
        s = '0; s.req = 1'b1;
        for (int i = 0; i < 6; i++) cycle(s, "tmo.wait");
        chk("tmo/err", 32'(hz.MemErr), 32'd1);
        s.rdy = 1'b1;
        cycle(s, "tmo.ready");
        s = '0;
        cycle(s, "tmo.sticky");
        chk("tmo/sticky", 32'(hz.MemErr), 32'd1);

        // Asynchronous reset while waiting on memory with the MDU busy.
        s = '0; s.mduStart = 1'b1;
        cycle(s, "rst.mdu");
        s = '0; s.req = 1'b1;
        cycle(s, "rst.req");
        cycle(s, "rst.wait");
        doReset("reset3");
        s = '0; s.mduUse = 1'b1;
        cycle(s, "rst.post");

        // Randomized traffic, including counter saturation.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset("reset4");
            s = '0;
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.wr       = 5'($urandom_range(0, 3));
            s.usesRs   = 1'($urandom_range(0, 1));
            s.usesRt   = 1'($urandom_range(0, 1));
            s.memRead  = ($urandom_range(0, 2) == 0);
            s.mduStart = ($urandom_range(0, 5) == 0);
            s.mduUse   = ($urandom_range(0, 2) == 0);
            s.branch   = ($urandom_range(0, 3) == 0);
            s.req      = ($urandom_range(0, 2) == 0);
            s.rdy      = ($urandom_range(0, 2) != 0);
            cycle(s, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
